// File: rtl/add_cmd_scheduler.sv
// Command-queued sequencer for the in-memory row adder: a small FIFO of {src_a, src_b, dst}
// commands feeding a CLEAR -> READ -> WRITE -> FINISH word-line sequencer, one add at a time.
module add_cmd_scheduler #(
  parameter int ROWS       = 8,
  parameter int ROW_W      = $clog2(ROWS),
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ROW_W-1:0] cmd_src_a,
  input  logic [ROW_W-1:0] cmd_src_b,
  input  logic [ROW_W-1:0] cmd_dst,
  output logic [ROWS-1:0]  RWLv1,
  output logic [ROWS-1:0]  RWLv2,
  output logic [ROWS-1:0]  WWLp,
  output logic             C_EN,
  output logic             CLR,
  output logic             DONE,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ROW_W-1:0] src_a;
    logic [ROW_W-1:0] src_b;
    logic [ROW_W-1:0] dst;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    READ,
    WRITE,
    FINISH
  } state_t;

  cmd_t            mem [FIFO_DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  cmd_t            head;
  cmd_t            op;
  state_t          state;

  function automatic logic [ROWS-1:0] row_sel(input logic [ROW_W-1:0] row);
    row_sel      = '0;
    row_sel[row] = 1'b1;
  endfunction

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = En && !empty && ((state == IDLE) || (state == FINISH));
  assign head      = mem[rd_ptr[ADDR_W-1:0]];
  assign busy      = (state != IDLE) || !empty;

  // NOTE: storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= '{src_a: cmd_src_a, src_b: cmd_src_b, dst: cmd_dst};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      RWLv1    <= '0;
      RWLv2    <= '0;
      WWLp     <= '0;
      C_EN     <= 1'b0;
      CLR      <= 1'b0;
      DONE     <= 1'b0;
      ops_done <= '0;
    end else begin
      // NOTE: outputs default low each cycle so every strobe lasts exactly one state.
      RWLv1 <= '0;
      RWLv2 <= '0;
      WWLp  <= '0;
      C_EN  <= 1'b0;
      CLR   <= 1'b0;
      DONE  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            op    <= head;
            CLR   <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          RWLv1 <= row_sel(op.src_a);
          RWLv2 <= row_sel(op.src_b);
          C_EN  <= 1'b1;
          state <= READ;
        end
        READ: begin
          WWLp  <= row_sel(op.dst);
          C_EN  <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          DONE     <= 1'b1;
          ops_done <= ops_done + CNT_W'(1);
          state    <= FINISH;
        end
        FINISH: begin
          if (pop) begin
            op    <= head;
            CLR   <= 1'b1;
            state <= CLEAR;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word-line buses carry at most one row, and read and write lines never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(RWLv1) && $onehot0(RWLv2) && $onehot0(WWLp));
      assert (!((|WWLp) && ((|RWLv1) || (|RWLv2))));
    end
  end

endmodule

// File: tb/tb_add_cmd_scheduler.sv
// Self-checking bench for add_cmd_scheduler: directed vector table, corner sequences and
// randomized traffic against a transaction-level model (command queue + op phase offset).
module tb_add_cmd_scheduler;

  localparam int ROWS     = 8;
  localparam int ROW_W    = 3;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 16;
  localparam int NARROW_W = 2;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] d;
  } cmd_t;

  typedef struct {
    bit          en;
    bit          valid;
    logic [8:0]  abd;
    logic [2:0]  ctl;
    logic [23:0] wl;
    logic [1:0]  st;
    logic [15:0] ops;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic cmd_valid;
  logic [ROW_W-1:0] a, b, d;

  logic             cmd_ready, C_EN, CLR, DONE, busy;
  logic [ROWS-1:0]  RWLv1, RWLv2, WWLp;
  logic [CNT_W-1:0] ops_done;

  logic                cmd_ready_n, C_EN_n, CLR_n, DONE_n, busy_n;
  logic [ROWS-1:0]     RWLv1_n, RWLv2_n, WWLp_n;
  logic [NARROW_W-1:0] ops_done_n;

  add_cmd_scheduler #(.ROWS(ROWS), .ROW_W(ROW_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .En(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_a(a), .cmd_src_b(b), .cmd_dst(d),
    .RWLv1(RWLv1), .RWLv2(RWLv2), .WWLp(WWLp), .C_EN(C_EN), .CLR(CLR), .DONE(DONE),
    .busy(busy), .ops_done(ops_done)
  );

  // Narrow-counter twin sees identical stimulus; its counter wraps every 4 ops.
  add_cmd_scheduler #(.ROWS(ROWS), .ROW_W(ROW_W), .FIFO_DEPTH(DEPTH), .CNT_W(NARROW_W)) dut_n (
    .clk(clk), .rst(rst), .En(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n),
    .cmd_src_a(a), .cmd_src_b(b), .cmd_dst(d),
    .RWLv1(RWLv1_n), .RWLv2(RWLv2_n), .WWLp(WWLp_n), .C_EN(C_EN_n), .CLR(CLR_n), .DONE(DONE_n),
    .busy(busy_n), .ops_done(ops_done_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued commands plus the active op and its phase offset
  // (0 clear, 1 read, 2 write, 3 done).
  cmd_t        q[$];
  bit          active;
  int          k;
  cmd_t        cur;
  int unsigned cnt;

  int   cyc;
  bit   track_done;
  int   last_done_cyc;
  int   issued[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] row_bit(input logic [2:0] r);
    return 8'd1 << r;
  endfunction

  function automatic int oh_index(input logic [7:0] v);
    int idx = -1;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    q.delete();
    active = 1'b0;
    k      = 0;
    cnt    = 0;
  endtask

  task automatic model_edge(input bit en_i, input bit v_i, input cmd_t c_i, output bit acc);
    bit ready = (q.size() < DEPTH);
    bit start = (!active || k == 3) && en_i && (q.size() > 0);
    if (start) begin
      cur    = q.pop_front();
      active = 1'b1;
      k      = 0;
    end else if (active && k < 3) begin
      k++;
      if (k == 3) cnt++;
    end else begin
      active = 1'b0;
    end
    acc = v_i && ready;
    if (acc) q.push_back(c_i);
  endtask

  task automatic compare_model();
    logic        e_clr, e_rd, e_wr, e_done, e_busy, e_ready;
    logic [7:0]  e_r1, e_r2, e_w;
    logic [31:0] e_all, n_all;
    e_clr   = active && (k == 0);
    e_rd    = active && (k == 1);
    e_wr    = active && (k == 2);
    e_done  = active && (k == 3);
    e_r1    = e_rd ? row_bit(cur.a) : 8'h00;
    e_r2    = e_rd ? row_bit(cur.b) : 8'h00;
    e_w     = e_wr ? row_bit(cur.d) : 8'h00;
    e_busy  = active || (q.size() > 0);
    e_ready = !rst && (q.size() < DEPTH);
    check("CLR", CLR, e_clr);
    check("C_EN", C_EN, e_rd || e_wr);
    check("DONE", DONE, e_done);
    check("RWLv1", RWLv1, e_r1);
    check("RWLv2", RWLv2, e_r2);
    check("WWLp", WWLp, e_w);
    check("busy", busy, e_busy);
    check("cmd_ready", cmd_ready, e_ready);
    check("ops_done", ops_done, cnt % 65536);
    check("ops_done_narrow", ops_done_n, cnt % 4);
    e_all = {3'b0, e_clr, e_rd || e_wr, e_done, e_r1, e_r2, e_w, e_busy, e_ready};
    n_all = {3'b0, CLR_n, C_EN_n, DONE_n, RWLv1_n, RWLv2_n, WWLp_n, busy_n, cmd_ready_n};
    check("narrow_outputs", n_all, e_all);
  endtask

  task automatic step(input bit en_i, input bit v_i, input cmd_t c_i, output bit acc);
    en        = en_i;
    cmd_valid = v_i;
    a         = c_i.a;
    b         = c_i.b;
    d         = c_i.d;
    @(posedge clk);
    model_edge(en_i, v_i, c_i, acc);
    @(negedge clk);
    cyc++;
    compare_model();
    if (C_EN && RWLv1 != 8'h00) issued.push_back(oh_index(RWLv1));
    if (track_done && DONE) begin
      if (last_done_cyc >= 0) check("done_spacing", cyc - last_done_cyc, 4);
      last_done_cyc = cyc;
    end
  endtask

  task automatic drain(input int budget);
    bit acc;
    int n = 0;
    while ((active || q.size() > 0) && n < budget) begin
      step(1'b1, 1'b0, '0, acc);
      n++;
    end
    check("drain_idle", busy, 1'b0);
  endtask

  vec_t vecs[12];
  cmd_t burst[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   idx, n, dones;
    bit   saw_full;
    cmd_t c;

    vecs[0]  = '{1'b1, 1'b1, 9'o257, 3'b000, 24'h000000, 2'b11, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 9'o000, 3'b100, 24'h000000, 2'b11, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 9'o000, 3'b010, 24'h042000, 2'b11, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 9'o000, 3'b010, 24'h000080, 2'b11, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 9'o000, 3'b001, 24'h000000, 2'b11, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 9'o000, 3'b000, 24'h000000, 2'b01, 16'd1};
    vecs[6]  = '{1'b1, 1'b1, 9'o000, 3'b000, 24'h000000, 2'b11, 16'd1};
    vecs[7]  = '{1'b1, 1'b0, 9'o000, 3'b100, 24'h000000, 2'b11, 16'd1};
    vecs[8]  = '{1'b1, 1'b0, 9'o000, 3'b010, 24'h010100, 2'b11, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 9'o000, 3'b010, 24'h000001, 2'b11, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 9'o000, 3'b001, 24'h000000, 2'b11, 16'd2};
    vecs[11] = '{1'b1, 1'b0, 9'o000, 3'b000, 24'h000000, 2'b01, 16'd2};

    burst[0] = '{3'd1, 3'd6, 3'd3};
    burst[1] = '{3'd4, 3'd4, 3'd2};
    burst[2] = '{3'd7, 3'd0, 3'd7};
    burst[3] = '{3'd3, 3'd5, 3'd1};
    burst[4] = '{3'd5, 3'd2, 3'd0};

    cyc = 0; track_done = 1'b0; last_done_cyc = -1;
    en = 1'b0; cmd_valid = 1'b0; a = '0; b = '0; d = '0;

    // Reset held for two cycles: everything low, including cmd_ready.
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {CLR, C_EN, DONE, RWLv1, RWLv2, WWLp, busy}, '0);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_ops", ops_done, 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Directed table: single op {2,5,7}, then the a=b=d=0 corner.
    for (int i = 0; i < 12; i++) begin
      c = vecs[i].abd;
      step(vecs[i].en, vecs[i].valid, c, acc);
      check($sformatf("vec%0d_ctl", i), {CLR, C_EN, DONE}, vecs[i].ctl);
      check($sformatf("vec%0d_wl", i), {RWLv1, RWLv2, WWLp}, vecs[i].wl);
      check($sformatf("vec%0d_st", i), {busy, cmd_ready}, vecs[i].st);
      check($sformatf("vec%0d_ops", i), ops_done, vecs[i].ops);
    end

    // Burst of five with no idle cycles; pushes stall while the FIFO is full.
    issued.delete();
    track_done = 1'b1; last_done_cyc = -1;
    idx = 0; n = 0; saw_full = 1'b0;
    while (idx < 5 && n < 60) begin
      step(1'b1, 1'b1, burst[idx], acc);
      if (acc) idx++;
      if (!cmd_ready) saw_full = 1'b1;
      n++;
    end
    check("burst_accepted", idx, 5);
    check("burst_saw_full", saw_full, 1'b1);
    drain(60);
    track_done = 1'b0;
    check("burst_ops", ops_done, 16'd7);
    check("burst_issue_count", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      check($sformatf("burst_order%0d", i), issued[i], burst[i].a);

    // En dropped during op1's READ: op1 completes, the rest wait with busy high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, burst[i], acc);
    step(1'b1, 1'b0, '0, acc);
    check("gate_clr", CLR, 1'b1);
    step(1'b1, 1'b0, '0, acc);
    check("gate_read", C_EN && (RWLv1 != 8'h00), 1'b1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, acc);
      if (DONE) dones++;
    end
    check("gate_one_done", dones, 1);
    check("gate_busy", busy, 1'b1);
    check("gate_ops", ops_done, 16'd8);
    drain(40);
    check("gate_resume_ops", ops_done, 16'd10);

    // Reset during WRITE with commands still queued.
    step(1'b1, 1'b1, '{3'd1, 3'd2, 3'd3}, acc);
    step(1'b1, 1'b1, '{3'd4, 3'd5, 3'd6}, acc);
    step(1'b1, 1'b1, '{3'd7, 3'd7, 3'd7}, acc);
    step(1'b1, 1'b0, '0, acc);
    check("midrst_in_write", WWLp, 8'h08);
    rst = 1'b1;
    #1;
    check("midrst_wwl_drop", WWLp, 8'h00);
    check("midrst_outputs", {CLR, C_EN, DONE, RWLv1, RWLv2, busy, cmd_ready}, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_done", DONE, 1'b0);
    check("midrst_ops", ops_done, 16'd0);
    rst = 1'b0;
    #1;
    check("midrst_fifo_empty", busy, 1'b0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0, acc);
      if (CLR || DONE) dones++;
    end
    check("midrst_discarded", dones, 0);

    // Randomized traffic against the model, with an occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        @(posedge clk);
        @(negedge clk);
        compare_model();
        rst = 1'b0;
        #1;
      end
      c.a = 3'($urandom_range(0, 7));
      c.b = 3'($urandom_range(0, 7));
      c.d = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, c, acc);
    end
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
